// File: rtl/b_data_pack_if.sv
// b_data_pack_if: input beat stream and packed output word stream of the B-operand packer
interface b_data_pack_if #(
    parameter int DATA_INPUT_WIDTH  = 256,
    parameter int DATA_OUTPUT_WIDTH = 512
);
    localparam int RATIO = DATA_OUTPUT_WIDTH / DATA_INPUT_WIDTH;

    logic                         valid_i;
    logic                         ready_o;
    logic [DATA_INPUT_WIDTH-1:0]  data_i;
    logic                         last_i;
    logic                         valid_o;
    logic                         ready_i;
    logic [DATA_OUTPUT_WIDTH-1:0] data_o;
    logic [RATIO-1:0]             keep_o;
    logic                         last_o;

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, keep_o, last_o
    );

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, keep_o, last_o
    );
endinterface

// File: rtl/b_data_pack.sv
// b_data_pack: packs narrow input beats into wide output words with backpressure and early flush
module b_data_pack #(
    parameter int DATA_INPUT_WIDTH  = 256,
    parameter int DATA_OUTPUT_WIDTH = 512,
    parameter int LANE_ORDER        = 0
) (
    input logic clk,
    input logic reset,
    b_data_pack_if.slave bus
);
    localparam int W     = DATA_INPUT_WIDTH;
    localparam int RATIO = DATA_OUTPUT_WIDTH / DATA_INPUT_WIDTH;
    localparam int CW    = $clog2(RATIO);

    if (RATIO < 2 || RATIO * W != DATA_OUTPUT_WIDTH) begin : g_bad_ratio
        $error("b_data_pack: DATA_OUTPUT_WIDTH must be an integer multiple >= 2 of DATA_INPUT_WIDTH");
    end

    logic [CW-1:0]                cnt;
    logic [CW-1:0]                lane;
    logic [DATA_OUTPUT_WIDTH-1:0] acc;
    logic [RATIO-1:0]             acc_keep;
    logic [DATA_OUTPUT_WIDTH-1:0] merged;
    logic [RATIO-1:0]             merged_keep;
    logic [DATA_OUTPUT_WIDTH-1:0] data_q;
    logic [RATIO-1:0]             keep_q;
    logic                         last_q;
    logic                         valid_q;
    logic                         ready;
    logic                         take;
    logic                         done;

    assign ready = ~valid_q | bus.ready_i;
    assign take  = bus.valid_i & ready;
    assign done  = (cnt == CW'(RATIO - 1)) | bus.last_i;
    assign lane  = (LANE_ORDER != 0) ? CW'(RATIO - 1) - cnt : cnt;

    // Current beat overlaid onto the accumulator in its physical lane
    always_comb begin
        merged      = acc;
        merged_keep = acc_keep;
        for (int k = 0; k < RATIO; k++) begin
            merged[k*W +: W] = (CW'(k) == lane) ? bus.data_i : acc[k*W +: W];
            merged_keep[k]   = (CW'(k) == lane) | acc_keep[k];
        end
    end

    // Accumulate beats and hand complete words to the output register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
            data_q   <= '0;
            keep_q   <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (valid_q && bus.ready_i)
                valid_q <= 1'b0;
            if (take && done) begin
                data_q   <= merged;
                keep_q   <= merged_keep;
                last_q   <= bus.last_i;
                valid_q  <= 1'b1;
                cnt      <= '0;
                acc      <= '0;
                acc_keep <= '0;
            end else if (take) begin
                cnt      <= cnt + CW'(1);
                acc      <= merged;
                acc_keep <= merged_keep;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.keep_o  = keep_q;
    assign bus.last_o  = last_q;
endmodule

// File: tb/tb_b_data_pack.sv
// tb_b_data_pack: directed vector table over three packer configurations plus reset sequences
module tb_b_data_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    b_data_pack_if #(256, 512)  if0 ();
    b_data_pack_if #(256, 1024) if1 ();
    b_data_pack_if #(256, 1024) if2 ();

    b_data_pack #(.DATA_INPUT_WIDTH(256), .DATA_OUTPUT_WIDTH(512),  .LANE_ORDER(0)) dut0 (.clk(clk), .reset(rst), .bus(if0));
    b_data_pack #(.DATA_INPUT_WIDTH(256), .DATA_OUTPUT_WIDTH(1024), .LANE_ORDER(0)) dut1 (.clk(clk), .reset(rst), .bus(if1));
    b_data_pack #(.DATA_INPUT_WIDTH(256), .DATA_OUTPUT_WIDTH(1024), .LANE_ORDER(1)) dut2 (.clk(clk), .reset(rst), .bus(if2));

    typedef struct {
        int           d;
        logic         v;
        logic         l;
        logic         r;
        logic [255:0] din;
        logic         ero;
        logic         evo;
        logic [1023:0] edo;
        logic [3:0]   ek;
        logic         el;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [255:0] b(input logic [7:0] n);
        return {32{n}};
    endfunction

    function automatic logic [1023:0] w2(input logic [255:0] hi, input logic [255:0] lo);
        return {512'b0, hi, lo};
    endfunction

    function automatic logic [1023:0] w4(input logic [255:0] l3, input logic [255:0] l2,
                                         input logic [255:0] l1, input logic [255:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic vec_t mk(input int d, input logic v, input logic l, input logic r,
                                input logic [255:0] din, input logic ero, input logic evo,
                                input logic [1023:0] edo, input logic [3:0] ek, input logic el);
        vec_t t;
        t.d = d; t.v = v; t.l = l; t.r = r; t.din = din;
        t.ero = ero; t.evo = evo; t.edo = edo; t.ek = ek; t.el = el;
        return t;
    endfunction

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input int d, input logic v, input logic l, input logic r, input logic [255:0] din);
        if0.valid_i = (d == 0) & v; if0.last_i = l; if0.data_i = din; if0.ready_i = (d == 0) ? r : 1'b1;
        if1.valid_i = (d == 1) & v; if1.last_i = l; if1.data_i = din; if1.ready_i = (d == 1) ? r : 1'b1;
        if2.valid_i = (d == 2) & v; if2.last_i = l; if2.data_i = din; if2.ready_i = (d == 2) ? r : 1'b1;
    endtask

    task automatic sample(input int d, output logic ro, output logic vo, output logic [1023:0] dout,
                          output logic [3:0] ko, output logic lo);
        case (d)
            0: begin ro = if0.ready_o; vo = if0.valid_o; dout = {512'b0, if0.data_o}; ko = {2'b0, if0.keep_o}; lo = if0.last_o; end
            1: begin ro = if1.ready_o; vo = if1.valid_o; dout = if1.data_o; ko = if1.keep_o; lo = if1.last_o; end
            default: begin ro = if2.ready_o; vo = if2.valid_o; dout = if2.data_o; ko = if2.keep_o; lo = if2.last_o; end
        endcase
    endtask

    task automatic step(input string tag, input vec_t t);
        logic ro, vo, lo;
        logic [1023:0] dout;
        logic [3:0] ko;
        drive(t.d, t.v, t.l, t.r, t.din);
        #1;
        sample(t.d, ro, vo, dout, ko, lo);
        chk({tag, " ready_o"}, 1024'(ro), 1024'(t.ero));
        @(posedge clk);
        #1;
        sample(t.d, ro, vo, dout, ko, lo);
        chk({tag, " valid_o"}, 1024'(vo), 1024'(t.evo));
        if (t.evo) begin
            chk({tag, " data_o"}, dout, t.edo);
            chk({tag, " keep_o"}, 1024'(ko), 1024'(t.ek));
            chk({tag, " last_o"}, 1024'(lo), 1024'(t.el));
        end
    endtask

    task automatic do_reset(input string tag);
        logic ro, vo, lo;
        logic [1023:0] dout;
        logic [3:0] ko;
        drive(1, 1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sample(1, ro, vo, dout, ko, lo);
        chk({tag, " rst ready_o"}, 1024'(ro), 1024'(1'b1));
        chk({tag, " rst valid_o"}, 1024'(vo), 1024'(1'b0));
        chk({tag, " rst data_o"}, dout, '0);
        chk({tag, " rst keep_o"}, 1024'(ko), '0);
        chk({tag, " rst last_o"}, 1024'(lo), '0);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b1, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset valid_o0", 1024'(if0.valid_o), '0);
        chk("reset data_o0", {512'b0, if0.data_o}, '0);
        chk("reset keep_o1", 1024'(if1.keep_o), '0);
        chk("reset last_o2", 1024'(if2.last_o), '0);
        chk("reset ready_o1", 1024'(if1.ready_o), 1024'(1'b1));

        tbl.push_back(mk(0, 1, 0, 1, b(1), 1, 0, '0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, b(2), 1, 1, w2(b(2), b(1)), 4'b0011, 0));
        tbl.push_back(mk(0, 0, 0, 1, '0,   1, 0, '0, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, 1, b(8'(3 + i)), 1, i[0], w2(b(8'(3 + i)), b(8'(2 + i))), 4'b0011, 0));
        tbl.push_back(mk(0, 0, 0, 1, '0,   1, 0, '0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, b(1), 1, 0, '0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, b(2), 1, 1, w2(b(2), b(1)), 4'b0011, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 0, 0, b(3), 0, 1, w2(b(2), b(1)), 4'b0011, 0));
        tbl.push_back(mk(0, 1, 0, 1, b(3), 1, 0, '0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, b(4), 1, 1, w2(b(4), b(3)), 4'b0011, 0));
        tbl.push_back(mk(0, 0, 0, 1, '0,   1, 0, '0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, b(5), 1, 0, '0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, b(6), 1, 1, w4('0, '0, b(6), b(5)), 4'b0011, 1));
        tbl.push_back(mk(1, 1, 1, 1, b(7), 1, 1, w4('0, '0, '0, b(7)), 4'b0001, 1));
        tbl.push_back(mk(1, 1, 0, 1, b(8), 1, 0, '0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, b(9), 1, 0, '0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, b(10), 1, 0, '0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, b(11), 1, 1, w4(b(11), b(10), b(9), b(8)), 4'b1111, 1));
        tbl.push_back(mk(1, 0, 0, 1, '0,   1, 0, '0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 1, b(12), 1, 0, '0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 1, b(13), 1, 0, '0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 1, b(14), 1, 0, '0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 1, b(15), 1, 1, w4(b(12), b(13), b(14), b(15)), 4'b1111, 0));
        tbl.push_back(mk(2, 1, 1, 1, b(16), 1, 1, w4(b(16), '0, '0, '0), 4'b1000, 1));
        tbl.push_back(mk(2, 0, 0, 1, '0,   1, 0, '0, 0, 0));

        foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

        for (int i = 0; i < 4; i++)
            step($sformatf("pend%0d", i), mk(1, 1, 0, 1, b(8'(20 + i)), 1, i == 3, w4(b(23), b(22), b(21), b(20)), 4'b1111, 0));
        step("pend hold", mk(1, 0, 0, 0, '0, 0, 1, w4(b(23), b(22), b(21), b(20)), 4'b1111, 0));
        do_reset("pending");
        step("part0", mk(1, 1, 0, 1, b(24), 1, 0, '0, 0, 0));
        step("part1", mk(1, 1, 0, 1, b(25), 1, 0, '0, 0, 0));
        do_reset("partial");
        step("fresh last", mk(1, 1, 1, 1, b(26), 1, 1, w4('0, '0, '0, b(26)), 4'b0001, 1));
        for (int i = 0; i < 4; i++)
            step($sformatf("fresh%0d", i), mk(1, 1, 0, 1, b(8'(27 + i)), 1, i == 3, w4(b(30), b(29), b(28), b(27)), 4'b1111, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
